// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer.
// Streams serial test patterns into a scan chain (valid/ready on si_*), pulses the
// functional capture phase, and streams the captured response out (valid/ready on so_*).
// Unload of pattern N overlaps with load of pattern N+1.
//
// Ports:
//   CK, RN           clock and asynchronous active-low reset (released synchronously)
//   start, abort     run request (sampled in IDLE) and synchronous abort
//   num_pat          pattern count, latched on an accepted start
//   si_data/valid    serial pattern input; si_ready is the handshake back
//   so_data/valid    registered response bit; so_ready is the sink handshake
//   SO / SI          chain tail input / chain head output
//   SE, CE           scan enable and chain clock enable
//   busy, done       activity flag and one-cycle completion pulse
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned NPAT_W    = 8,
  parameter int unsigned CAP_CYC   = 1
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  input  logic              abort,
  input  logic [NPAT_W-1:0] num_pat,
  input  logic              si_data,
  input  logic              si_valid,
  output logic              si_ready,
  output logic              so_data,
  output logic              so_valid,
  input  logic              so_ready,
  input  logic              SO,
  output logic              SI,
  output logic              SE,
  output logic              CE,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BitW = $clog2(CHAIN_LEN);
  localparam int unsigned CapW = (CAP_CYC > 1) ? $clog2(CAP_CYC) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(CHAIN_LEN - 1);
  localparam logic [CapW-1:0] CapLast = CapW'(CAP_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StCapture, StShift, StUnload, StFin
  } state_e;

  // Reset asserts asynchronously, releases two CK edges after RN rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) rst_sync_q <= 2'b00;
    else     rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CapW-1:0]   cap_cnt_q, cap_cnt_d;
  logic [NPAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [NPAT_W-1:0] num_pat_q, num_pat_d;
  logic [NPAT_W-1:0] pat_next;
  logic              so_data_q, so_data_d;
  logic              so_valid_q, so_valid_d;
  logic              fire;

  always_ff @(posedge CK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      pat_cnt_q  <= '0;
      num_pat_q  <= '0;
      so_data_q  <= 1'b0;
      so_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      pat_cnt_q  <= pat_cnt_d;
      num_pat_q  <= num_pat_d;
      so_data_q  <= so_data_d;
      so_valid_q <= so_valid_d;
    end
  end

  assign pat_next = pat_cnt_q + NPAT_W'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    pat_cnt_d  = pat_cnt_q;
    num_pat_d  = num_pat_q;
    so_data_d  = so_data_q;
    so_valid_d = 1'b0;
    fire       = 1'b0;
    SE         = 1'b0;
    CE         = 1'b0;
    SI         = 1'b0;
    si_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_pat_d = num_pat;
          bit_cnt_d = '0;
          pat_cnt_d = '0;
          state_d   = (num_pat == '0) ? StFin : StLoad;
        end
      end
      StLoad: begin
        SE       = 1'b1;
        si_ready = 1'b1;
        fire     = si_valid;
        CE       = fire;
        SI       = fire & si_data;
      end
      StCapture: begin
        CE = 1'b1;
        if (cap_cnt_q == CapLast) begin
          pat_cnt_d = pat_next;
          bit_cnt_d = '0;
          state_d   = (pat_next < num_pat_q) ? StShift : StUnload;
        end else begin
          cap_cnt_d = cap_cnt_q + CapW'(1);
        end
      end
      StShift: begin
        SE       = 1'b1;
        si_ready = so_ready;
        fire     = si_valid & so_ready;
        CE       = fire;
        SI       = si_data;
      end
      StUnload: begin
        SE   = 1'b1;
        fire = so_ready;
        CE   = fire;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared bit-count / response handling for the three shifting states.
    if (fire) begin
      if (state_q != StLoad) begin
        so_data_d  = SO;
        so_valid_d = 1'b1;
      end
      if (bit_cnt_q == BitLast) begin
        bit_cnt_d = '0;
        cap_cnt_d = '0;
        state_d   = (state_q == StUnload) ? StFin : StCapture;
      end else begin
        bit_cnt_d = bit_cnt_q + BitW'(1);
      end
    end

    // Abort beats everything, including a handshake in the same cycle.
    if (abort) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      cap_cnt_d  = '0;
      pat_cnt_d  = '0;
      so_data_d  = so_data_q;
      so_valid_d = 1'b0;
      CE         = 1'b0;
      SI         = 1'b0;
      si_ready   = 1'b0;
    end
  end

  assign so_data  = so_data_q;
  assign so_valid = so_valid_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin) & ~abort;

endmodule
